// File: rtl/pwm_capture.sv
// PWM capture: measures high time and period of a synchronized PWM input between
// consecutive rising edges, with stuck-line timeout and a valid/ready result port.
module pwm_capture #(
    parameter int CntDw = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic             pwm_i,
    input  logic [CntDw-1:0] timeout_i,
    output logic             meas_valid_o,
    input  logic             meas_ready_i,
    output logic [CntDw-1:0] high_o,
    output logic [CntDw-1:0] period_o,
    output logic             sat_o,
    output logic             overrun_o,
    output logic             stuck_o,
    output logic             stuck_level_o,
    output logic [1:0]       state_o
);
    // Handshake: a result transfers in any cycle where meas_valid_o and meas_ready_i
    // are both 1; while meas_valid_o=1 and meas_ready_i=0 the result is held stable.

    typedef enum logic [1:0] {
        DISABLED  = 2'd0,
        ARM       = 2'd1,
        MEAS_HIGH = 2'd2,
        MEAS_LOW  = 2'd3
    } state_e;

    localparam logic [CntDw-1:0] CntMax = '1;
    localparam logic [CntDw-1:0] CntOne = CntDw'(1);

    state_e           state_q, state_d;
    logic             sync1_q, sync2_q, dly_q;
    logic             rise, fall;
    logic [CntDw-1:0] period_cnt, high_cnt, idle_cnt;
    logic             sat_acc;
    logic             start, fall_hit, complete, tmo, cnt_clr, idle_hit;

    function automatic logic [CntDw-1:0] sat_inc(input logic [CntDw-1:0] v);
        return (v == CntMax) ? v : v + CntOne;
    endfunction

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            dly_q   <= 1'b0;
        end else begin
            sync1_q <= pwm_i;
            sync2_q <= sync1_q;
            dly_q   <= sync2_q;
        end
    end

    assign rise     = sync2_q & ~dly_q;
    assign fall     = ~sync2_q & dly_q;
    assign idle_hit = (timeout_i != '0) && (idle_cnt >= timeout_i);
    assign state_o  = state_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= DISABLED;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        start    = 1'b0;
        fall_hit = 1'b0;
        complete = 1'b0;
        tmo      = 1'b0;
        cnt_clr  = 1'b0;
        if (!en_i) begin
            state_d = DISABLED;
            cnt_clr = 1'b1;
        end else begin
            case (state_q)
                DISABLED: state_d = ARM;
                ARM: begin
                    if (rise) begin
                        state_d = MEAS_HIGH;
                        start   = 1'b1;
                    end
                end
                MEAS_HIGH: begin
                    if (fall) begin
                        state_d  = MEAS_LOW;
                        fall_hit = 1'b1;
                    end else if (idle_hit) begin
                        state_d = ARM;
                        tmo     = 1'b1;
                        cnt_clr = 1'b1;
                    end
                end
                MEAS_LOW: begin
                    if (rise) begin
                        state_d  = MEAS_HIGH;
                        complete = 1'b1;
                        start    = 1'b1;
                    end else if (idle_hit) begin
                        state_d = ARM;
                        tmo     = 1'b1;
                        cnt_clr = 1'b1;
                    end
                end
                default: state_d = DISABLED;
            endcase
        end
    end

    // idle_cnt counts cycles since the last edge; sat_acc records any blocked increment.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            period_cnt <= '0;
            high_cnt   <= '0;
            idle_cnt   <= '0;
            sat_acc    <= 1'b0;
        end else if (cnt_clr) begin
            period_cnt <= '0;
            high_cnt   <= '0;
            idle_cnt   <= '0;
            sat_acc    <= 1'b0;
        end else if (start) begin
            period_cnt <= CntOne;
            high_cnt   <= CntOne;
            idle_cnt   <= CntOne;
            sat_acc    <= 1'b0;
        end else if (state_q == MEAS_HIGH) begin
            period_cnt <= sat_inc(period_cnt);
            idle_cnt   <= fall_hit ? CntOne : sat_inc(idle_cnt);
            if (!fall_hit) high_cnt <= sat_inc(high_cnt);
            sat_acc <= sat_acc | (period_cnt == CntMax) | (!fall_hit && (high_cnt == CntMax));
        end else if (state_q == MEAS_LOW) begin
            period_cnt <= sat_inc(period_cnt);
            idle_cnt   <= sat_inc(idle_cnt);
            sat_acc    <= sat_acc | (period_cnt == CntMax);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meas_valid_o  <= 1'b0;
            high_o        <= '0;
            period_o      <= '0;
            sat_o         <= 1'b0;
            overrun_o     <= 1'b0;
            stuck_o       <= 1'b0;
            stuck_level_o <= 1'b0;
        end else begin
            if (complete) begin
                if (!meas_valid_o || meas_ready_i) begin
                    meas_valid_o <= 1'b1;
                    high_o       <= high_cnt;
                    period_o     <= period_cnt;
                    sat_o        <= sat_acc;
                end else begin
                    overrun_o <= 1'b1;
                end
            end else if (meas_valid_o && meas_ready_i) begin
                meas_valid_o <= 1'b0;
            end
            if (tmo) begin
                stuck_o       <= 1'b1;
                stuck_level_o <= sync2_q;
            end
        end
    end

endmodule

// File: tb/tb_pwm_capture.sv
// Self-checking bench for pwm_capture: table-driven PWM waveforms, randomized
// periods against a period/high model, and hand-written corner sequences.
module tb_pwm_capture;
    localparam int W  = 16;
    localparam int W4 = 4;

    logic          clk;
    logic          rst_n;
    logic          en, pwm, ready, valid, sat, overrun, stuck, stuck_level;
    logic [W-1:0]  timeout, high, period;
    logic [1:0]    state;
    logic          en4, pwm4, ready4, valid4, sat4, overrun4, stuck4, stuck_level4;
    logic [W4-1:0] timeout4, high4, period4;
    logic [1:0]    state4;

    typedef struct packed {
        logic [W-1:0] high;
        logic [W-1:0] period;
        logic         sat;
    } res_t;

    typedef struct packed {
        logic [W4-1:0] high;
        logic [W4-1:0] period;
        logic          sat;
    } res4_t;

    typedef struct {
        int hi;
        int lo;
        int reps;
        int exp_high;
        int exp_period;
        int exp_sat;
    } vec_t;

    res_t  exp_q[$];
    res4_t got4[$];
    res_t  mon_e;
    int    n_checks = 0;
    int    n_errors = 0;

    pwm_capture #(.CntDw(W)) u_dut (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en), .pwm_i(pwm), .timeout_i(timeout),
        .meas_valid_o(valid), .meas_ready_i(ready), .high_o(high), .period_o(period),
        .sat_o(sat), .overrun_o(overrun), .stuck_o(stuck), .stuck_level_o(stuck_level),
        .state_o(state)
    );

    pwm_capture #(.CntDw(W4)) u_dut4 (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en4), .pwm_i(pwm4), .timeout_i(timeout4),
        .meas_valid_o(valid4), .meas_ready_i(ready4), .high_o(high4), .period_o(period4),
        .sat_o(sat4), .overrun_o(overrun4), .stuck_o(stuck4), .stuck_level_o(stuck_level4),
        .state_o(state4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic seg(input logic lvl, input int n);
        pwm = lvl;
        repeat (n) tick();
    endtask

    task automatic seg4(input logic lvl, input int n);
        pwm4 = lvl;
        repeat (n) tick();
    endtask

    task automatic setup_phase();
        ready = 1'b1;
        pwm   = 1'b0;
        en    = 1'b0;
        repeat (3) tick();
        en = 1'b1;
        repeat (5) tick();
    endtask

    task automatic drain(input string name);
        repeat (10) tick();
        check(name, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic push_exp(input int h, input int p, input logic s);
        exp_q.push_back('{high: W'(h), period: W'(p), sat: s});
    endtask

    // Scoreboard: every handshake on the main instance consumes one expected result.
    always @(negedge clk) begin
        if (rst_n && valid && ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_result: got high=%0d period=%0d sat=%0d, none expected",
                         high, period, sat);
            end else begin
                mon_e = exp_q.pop_front();
                check("result_high", 32'(high), 32'(mon_e.high));
                check("result_period", 32'(period), 32'(mon_e.period));
                check("result_sat", 32'(sat), 32'(mon_e.sat));
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && valid4 && ready4) got4.push_back('{high: high4, period: period4, sat: sat4});
    end

    initial begin
        vec_t vecs[6];
        int   hs[40];
        int   ls[40];
        int   cnt;
        logic saw_valid;

        vecs[0] = '{2, 6, 5, 2, 8, 0};
        vecs[1] = '{1, 1, 6, 1, 2, 0};
        vecs[2] = '{5, 5, 3, 5, 10, 0};
        vecs[3] = '{1, 7, 3, 1, 8, 0};
        vecs[4] = '{7, 1, 3, 7, 8, 0};
        vecs[5] = '{3, 100, 2, 3, 103, 0};

        rst_n = 1'b0; en = 1'b0; pwm = 1'b0; ready = 1'b0; timeout = '0;
        en4 = 1'b0; pwm4 = 1'b0; ready4 = 1'b1; timeout4 = '0;
        repeat (3) tick();
        check("reset_valid", 32'(valid), 32'd0);
        check("reset_high", 32'(high), 32'd0);
        check("reset_period", 32'(period), 32'd0);
        check("reset_sat", 32'(sat), 32'd0);
        check("reset_overrun", 32'(overrun), 32'd0);
        check("reset_stuck", 32'(stuck), 32'd0);
        check("reset_stuck_level", 32'(stuck_level), 32'd0);
        check("reset_state", 32'(state), 32'd0);
        rst_n = 1'b1;
        en4 = 1'b1;
        tick();

        // Table-driven fixed waveforms: reps completed periods each.
        for (int v = 0; v < 6; v++) begin
            setup_phase();
            for (int r = 0; r < vecs[v].reps; r++)
                push_exp(vecs[v].exp_high, vecs[v].exp_period, 1'(vecs[v].exp_sat));
            for (int r = 0; r < vecs[v].reps; r++) begin
                seg(1'b1, vecs[v].hi);
                seg(1'b0, vecs[v].lo);
            end
            seg(1'b1, 1);
            pwm = 1'b0;
            drain($sformatf("table_drain_%0d", v));
        end

        // Randomized periods: period k completes at the start of high segment k+1.
        setup_phase();
        for (int i = 0; i < 40; i++) begin
            hs[i] = int'($urandom_range(1, 12));
            ls[i] = int'($urandom_range(1, 12));
        end
        for (int i = 0; i < 39; i++) push_exp(hs[i], hs[i] + ls[i], 1'b0);
        for (int i = 0; i < 40; i++) begin
            seg(1'b1, hs[i]);
            seg(1'b0, ls[i]);
        end
        drain("random_drain");

        // Saturation on the 4-bit instance, then a clean period clears sat.
        seg4(1'b1, 20);
        seg4(1'b0, 10);
        seg4(1'b1, 2);
        seg4(1'b0, 3);
        seg4(1'b1, 1);
        pwm4 = 1'b0;
        repeat (8) tick();
        check("sat4_count", 32'(got4.size()), 32'd2);
        if (got4.size() >= 2) begin
            check("sat4_high", 32'(got4[0].high), 32'd15);
            check("sat4_period", 32'(got4[0].period), 32'd15);
            check("sat4_sat", 32'(got4[0].sat), 32'd1);
            check("sat4_next_high", 32'(got4[1].high), 32'd2);
            check("sat4_next_period", 32'(got4[1].period), 32'd5);
            check("sat4_next_sat", 32'(got4[1].sat), 32'd0);
        end

        // Result held with ready low; later completions set overrun.
        setup_phase();
        ready = 1'b0;
        check("overrun_before", 32'(overrun), 32'd0);
        repeat (4) begin
            seg(1'b1, 5);
            seg(1'b0, 5);
        end
        repeat (5) tick();
        check("hold_valid", 32'(valid), 32'd1);
        check("hold_high", 32'(high), 32'd5);
        check("hold_period", 32'(period), 32'd10);
        check("hold_overrun", 32'(overrun), 32'd1);
        push_exp(5, 10, 1'b0);
        ready = 1'b1;
        tick();
        ready = 1'b0;
        check("valid_drop", 32'(valid), 32'd0);
        check("overrun_sticky", 32'(overrun), 32'd1);
        check("hold_drain", 32'(exp_q.size()), 32'd0);

        // Disable mid-low: interrupted period yields nothing, next period is exact.
        setup_phase();
        push_exp(4, 10, 1'b0);
        seg(1'b1, 4);
        seg(1'b0, 5);
        en = 1'b0;
        repeat (2) tick();
        en = 1'b1;
        seg(1'b0, 3);
        seg(1'b1, 4);
        seg(1'b0, 6);
        seg(1'b1, 1);
        pwm = 1'b0;
        drain("enable_toggle_drain");

        // Stuck-high timeout.
        setup_phase();
        timeout = W'(50);
        saw_valid = 1'b0;
        check("stuck_before", 32'(stuck), 32'd0);
        pwm = 1'b1;
        cnt = 0;
        while (!stuck && cnt < 300) begin
            tick();
            cnt++;
            if (valid) saw_valid = 1'b1;
        end
        check("stuck_set", 32'(stuck), 32'd1);
        check("stuck_level_high", 32'(stuck_level), 32'd1);
        check("stuck_state_arm", 32'(state), 32'd1);
        check("stuck_no_valid", 32'(saw_valid), 32'd0);
        n_checks++;
        if (cnt < 50 || cnt > 56) begin
            n_errors++;
            $display("FAIL stuck_latency: actual=%0d cycles required=50..56", cnt);
        end

        // Stuck-low timeout after a fall.
        seg(1'b0, 5);
        seg(1'b1, 3);
        pwm = 1'b0;
        cnt = 0;
        while (stuck_level && cnt < 300) begin
            tick();
            cnt++;
            if (valid) saw_valid = 1'b1;
        end
        check("stuck_level_low", 32'(stuck_level), 32'd0);
        check("stuck_low_state_arm", 32'(state), 32'd1);
        check("stuck_low_no_valid", 32'(saw_valid), 32'd0);
        n_checks++;
        if (cnt < 50 || cnt > 56) begin
            n_errors++;
            $display("FAIL stuck_low_latency: actual=%0d cycles required=50..56", cnt);
        end
        timeout = '0;

        // Asynchronous reset mid-high with a result pending.
        setup_phase();
        ready = 1'b0;
        seg(1'b1, 3);
        seg(1'b0, 3);
        seg(1'b1, 5);
        check("pending_before_reset", 32'(valid), 32'd1);
        check("state_meas_high", 32'(state), 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_valid", 32'(valid), 32'd0);
        check("async_high", 32'(high), 32'd0);
        check("async_period", 32'(period), 32'd0);
        check("async_sat", 32'(sat), 32'd0);
        check("async_overrun", 32'(overrun), 32'd0);
        check("async_stuck", 32'(stuck), 32'd0);
        check("async_stuck_level", 32'(stuck_level), 32'd0);
        check("async_state", 32'(state), 32'd0);
        repeat (2) tick();
        pwm = 1'b0;
        ready = 1'b1;
        rst_n = 1'b1;
        drain("post_reset_drain");
        check("post_reset_valid", 32'(valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
